// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and constants for the data memory arbiter
// Purpose: arbiter FSM state encoding, requester ids and the default memory
//          geometry shared with the data memory itself.
// Ports:   none (package).
package dmem_arbiter_pkg;

  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_DEPTH  = 64;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DMA  = 1'b1;

  typedef enum logic [1:0] {
    ST_ARB  = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_resp_reg.sv
// rtl/dmem_arbiter_resp_reg.sv - per-requester registered response stage
// Purpose: turns a grant into a one-cycle rvalid pulse with err and read data.
// Ports:   clk, rst (async, active-high)
//          i_gnt   - requester granted this cycle
//          i_we    - granted access is a write
//          i_bad   - granted access failed alignment/range check
//          i_rdata - memory async read data
//          o_rvalid, o_rdata, o_err - registered response
module dmem_resp_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_gnt,
  input  logic              i_we,
  input  logic              i_bad,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_err
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rvalid <= 1'b0;
      o_err    <= 1'b0;
      o_rdata  <= '0;
    end else begin
      o_rvalid <= i_gnt;
      if (i_gnt) begin
        o_err   <= i_bad;
        // Only a good read returns memory data; writes and errors return zero.
        o_rdata <= (i_we || i_bad) ? '0 : i_rdata;
      end else begin
        o_err   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter in front of the data memory
// Purpose: grants one access per cycle between core (m0) and DMA (m1), with
//          optional lock for bursts, byte->word address conversion,
//          alignment/range checking and registered responses.
// Ports:   clk, rst (async, active-high)
//          mX_req/we/lock/addr/wdata - requester X access
//          mX_gnt (comb), mX_rvalid/rdata/err (registered)
//          mem_a/mem_we/mem_wd - memory drive, mem_rd - memory async read data
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W    = DMEM_DATA_W,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = DMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam logic [ADDR_W-3:0] LP_DEPTH = (ADDR_W-2)'(MEM_DEPTH);

  function automatic logic f_bad(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || (a[ADDR_W-1:2] >= LP_DEPTH);
  endfunction

  arb_state_t r_state;
  logic       r_rr_last;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_bad0;
  logic       w_bad1;

  assign w_bad0 = f_bad(m0_addr);
  assign w_bad1 = f_bad(m1_addr);

  // Grant decode; everything is held off while reset is asserted.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst) begin
      unique case (r_state)
        ST_ARB: begin
          if (m0_req && m1_req) begin
            // Tie goes to whoever was not granted last.
            w_gnt0 = (r_rr_last != REQ_CORE);
            w_gnt1 = ~w_gnt0;
          end else begin
            w_gnt0 = m0_req;
            w_gnt1 = m1_req;
          end
        end
        ST_OWN0: w_gnt0 = m0_req;
        ST_OWN1: w_gnt1 = m1_req;
        default: ;
      endcase
    end
  end

  assign m0_gnt = w_gnt0;
  assign m1_gnt = w_gnt1;

  always_comb begin
    mem_a  = '0;
    mem_we = 1'b0;
    mem_wd = '0;
    if (w_gnt0) begin
      mem_a  = {2'b00, m0_addr[ADDR_W-1:2]};
      mem_we = m0_we & ~w_bad0;
      mem_wd = m0_wdata;
    end else if (w_gnt1) begin
      mem_a  = {2'b00, m1_addr[ADDR_W-1:2]};
      mem_we = m1_we & ~w_bad1;
      mem_wd = m1_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_ARB;
      r_rr_last <= REQ_DMA;
    end else begin
      unique case (r_state)
        ST_ARB: begin
          if (w_gnt0) begin
            r_rr_last <= REQ_CORE;
            if (m0_lock) r_state <= ST_OWN0;
          end else if (w_gnt1) begin
            r_rr_last <= REQ_DMA;
            if (m1_lock) r_state <= ST_OWN1;
          end
        end
        ST_OWN0: begin
          if (w_gnt0) r_rr_last <= REQ_CORE;
          // Dropping lock releases ownership whether or not a grant happened.
          if (!m0_lock) r_state <= ST_ARB;
        end
        ST_OWN1: begin
          if (w_gnt1) r_rr_last <= REQ_DMA;
          if (!m1_lock) r_state <= ST_ARB;
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end

  dmem_resp_reg #(.DATA_W(DATA_W)) u_resp0 (
    .clk      (clk),
    .rst      (rst),
    .i_gnt    (w_gnt0),
    .i_we     (m0_we),
    .i_bad    (w_bad0),
    .i_rdata  (mem_rd),
    .o_rvalid (m0_rvalid),
    .o_rdata  (m0_rdata),
    .o_err    (m0_err)
  );

  dmem_resp_reg #(.DATA_W(DATA_W)) u_resp1 (
    .clk      (clk),
    .rst      (rst),
    .i_gnt    (w_gnt1),
    .i_we     (m1_we),
    .i_bad    (w_bad1),
    .i_rdata  (mem_rd),
    .o_rvalid (m1_rvalid),
    .o_rdata  (m1_rdata),
    .o_err    (m1_err)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m0_lock;
  logic [31:0] m0_addr, m0_wdata;
  logic        m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_req, m1_we, m1_lock;
  logic [31:0] m1_addr, m1_wdata;
  logic        m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_rdata;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;
  logic        mem_clr;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_arbiter u_dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // 64-word memory behind the arbiter: async read, write on posedge.
  logic [31:0] r_mem [64];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) r_mem[i] <= '0;
    end else if (mem_we) begin
      r_mem[mem_a[5:0]] <= mem_wd;
    end
  end
  assign mem_rd = r_mem[mem_a[5:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic r0, w0, l0; logic [31:0] a0, d0;
    logic r1, w1, l1; logic [31:0] a1, d1;
    logic g0, g1, mwe; logic [31:0] ma;
    logic v0, e0; logic [31:0] rd0;
    logic v1, e1; logic [31:0] rd1;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    input logic r0, w0, l0, input logic [31:0] a0, d0,
    input logic r1, w1, l1, input logic [31:0] a1, d1,
    input logic g0, g1, mwe, input logic [31:0] ma,
    input logic v0, e0, input logic [31:0] rd0,
    input logic v1, e1, input logic [31:0] rd1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.mwe = mwe; v.ma = ma;
    v.v0 = v0; v.e0 = e0; v.rd0 = rd0;
    v.v1 = v1; v.e1 = e1; v.rd1 = rd1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r0, w0, l0, input logic [31:0] a0, d0,
                       input logic r1, w1, l1, input logic [31:0] a1, d1);
    m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
  endtask

  initial begin
    rst = 1'b1;
    mem_clr = 1'b1;
    drive(1, 1, 0, 32'h8, 32'h1, 0, 0, 0, 0, 0);

    // Columns: m0 req/we/lock/addr/wdata, m1 req/we/lock/addr/wdata,
    //          exp gnt0/gnt1/mem_we/mem_a, exp m0 rvalid/err/rdata, exp m1 rvalid/err/rdata
    vt.push_back(mk(1,1,0,32'h008,32'hDEADBEEF, 0,0,0,0,0,           1,0,1,2,     0,0,0,            0,0,0));
    vt.push_back(mk(1,0,0,32'h008,0,            0,0,0,0,0,           1,0,0,2,     1,0,0,            0,0,0));
    vt.push_back(mk(0,0,0,0,0,                  1,0,0,32'h000,0,     0,1,0,0,     1,0,32'hDEADBEEF, 0,0,0));
    vt.push_back(mk(1,0,0,32'h008,0,            1,0,0,32'h008,0,     1,0,0,2,     0,0,32'hDEADBEEF, 1,0,0));
    vt.push_back(mk(1,0,0,32'h008,0,            1,0,0,32'h008,0,     0,1,0,2,     1,0,32'hDEADBEEF, 0,0,0));
    vt.push_back(mk(1,0,0,32'h008,0,            1,0,0,32'h008,0,     1,0,0,2,     0,0,32'hDEADBEEF, 1,0,32'hDEADBEEF));
    vt.push_back(mk(1,0,0,32'h008,0,            1,0,0,32'h008,0,     0,1,0,2,     1,0,32'hDEADBEEF, 0,0,32'hDEADBEEF));
    vt.push_back(mk(1,0,0,32'h008,0,            0,0,0,0,0,           1,0,0,2,     0,0,32'hDEADBEEF, 1,0,32'hDEADBEEF));
    vt.push_back(mk(1,0,0,32'h008,0,            1,1,1,32'h010,32'hA0,0,1,1,4,     1,0,32'hDEADBEEF, 0,0,32'hDEADBEEF));
    vt.push_back(mk(1,0,0,32'h008,0,            1,1,1,32'h014,32'hA1,0,1,1,5,     0,0,32'hDEADBEEF, 1,0,0));
    vt.push_back(mk(1,0,0,32'h008,0,            1,1,0,32'h018,32'hA2,0,1,1,6,     0,0,32'hDEADBEEF, 1,0,0));
    vt.push_back(mk(1,0,0,32'h010,0,            0,0,0,0,0,           1,0,0,4,     0,0,32'hDEADBEEF, 1,0,0));
    vt.push_back(mk(1,0,0,32'h018,0,            0,0,0,0,0,           1,0,0,6,     1,0,32'hA0,       0,0,0));
    vt.push_back(mk(1,1,0,32'h00A,32'hBAD,      0,0,0,0,0,           1,0,0,2,     1,0,32'hA2,       0,0,0));
    vt.push_back(mk(1,1,0,32'h100,32'hBAD,      0,0,0,0,0,           1,0,0,32'h40,1,1,0,            0,0,0));
    vt.push_back(mk(1,1,0,32'h0FC,32'h5A5A,     0,0,0,0,0,           1,0,1,32'h3F,1,1,0,            0,0,0));
    vt.push_back(mk(1,0,0,32'h0FC,0,            0,0,0,0,0,           1,0,0,32'h3F,1,0,0,            0,0,0));
    vt.push_back(mk(1,0,0,32'h000,0,            0,0,0,0,0,           1,0,0,0,     1,0,32'h5A5A,     0,0,0));
    vt.push_back(mk(1,0,0,32'h008,0,            0,0,0,0,0,           1,0,0,2,     1,0,0,            0,0,0));
    vt.push_back(mk(0,0,0,0,0,                  1,1,0,32'h020,32'h1234,0,1,1,8,   1,0,32'hDEADBEEF, 0,0,0));
    vt.push_back(mk(1,0,0,32'h020,0,            0,0,0,0,0,           1,0,0,8,     0,0,32'hDEADBEEF, 1,0,0));
    vt.push_back(mk(0,0,0,0,0,                  0,0,0,0,0,           0,0,0,0,     1,0,32'h1234,     0,0,0));
    vt.push_back(mk(1,0,1,32'h008,0,            0,0,0,0,0,           1,0,0,2,     0,0,32'h1234,     0,0,0));
    vt.push_back(mk(0,0,1,0,0,                  1,0,0,32'h008,0,     0,0,0,0,     1,0,32'hDEADBEEF, 0,0,0));
    vt.push_back(mk(0,0,0,0,0,                  1,0,0,32'h008,0,     0,0,0,0,     0,0,32'hDEADBEEF, 0,0,0));
    vt.push_back(mk(0,0,0,0,0,                  1,0,0,32'h008,0,     0,1,0,2,     0,0,32'hDEADBEEF, 0,0,0));
    vt.push_back(mk(0,0,0,0,0,                  0,0,0,0,0,           0,0,0,0,     0,0,32'hDEADBEEF, 1,0,32'hDEADBEEF));

    // Reset state, with a request pending that must not be granted.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt0", {31'b0, m0_gnt}, 0);
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    chk("rst_rvalid0", {31'b0, m0_rvalid}, 0);
    chk("rst_rvalid1", {31'b0, m1_rvalid}, 0);
    chk("rst_rdata0", m0_rdata, 0);
    chk("rst_err0", {31'b0, m0_err}, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_clr = 1'b0;
    #2 rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vt[i].r0, vt[i].w0, vt[i].l0, vt[i].a0, vt[i].d0,
            vt[i].r1, vt[i].w1, vt[i].l1, vt[i].a1, vt[i].d1);
      #4;
      chk($sformatf("v%0d_gnt0", i), {31'b0, m0_gnt}, {31'b0, vt[i].g0});
      chk($sformatf("v%0d_gnt1", i), {31'b0, m1_gnt}, {31'b0, vt[i].g1});
      chk($sformatf("v%0d_mem_we", i), {31'b0, mem_we}, {31'b0, vt[i].mwe});
      chk($sformatf("v%0d_mem_a", i), mem_a, vt[i].ma);
      chk($sformatf("v%0d_rvalid0", i), {31'b0, m0_rvalid}, {31'b0, vt[i].v0});
      chk($sformatf("v%0d_err0", i), {31'b0, m0_err}, {31'b0, vt[i].e0});
      chk($sformatf("v%0d_rdata0", i), m0_rdata, vt[i].rd0);
      chk($sformatf("v%0d_rvalid1", i), {31'b0, m1_rvalid}, {31'b0, vt[i].v1});
      chk($sformatf("v%0d_err1", i), {31'b0, m1_err}, {31'b0, vt[i].e1});
      chk($sformatf("v%0d_rdata1", i), m1_rdata, vt[i].rd1);
    end

    // Reset asserted mid-cycle during an m1 locked burst.
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0, 1, 1, 1, 32'h030, 32'h77);
    #4 chk("burst_a_gnt1", {31'b0, m1_gnt}, 1);
    @(posedge clk);
    #1 drive(1, 0, 0, 32'h034, 0, 1, 1, 1, 32'h034, 32'h88);
    #1;
    chk("burst_b_gnt1", {31'b0, m1_gnt}, 1);
    chk("burst_b_gnt0", {31'b0, m0_gnt}, 0);
    chk("burst_b_mem_we", {31'b0, mem_we}, 1);
    chk("burst_b_rvalid1", {31'b0, m1_rvalid}, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_gnt1", {31'b0, m1_gnt}, 0);
    chk("arst_gnt0", {31'b0, m0_gnt}, 0);
    chk("arst_mem_we", {31'b0, mem_we}, 0);
    chk("arst_rvalid1", {31'b0, m1_rvalid}, 0);
    chk("arst_rdata0", m0_rdata, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1, 0, 0, 32'h034, 0, 1, 0, 0, 32'h034, 0);
    #1;
    chk("post_rst_tie_gnt0", {31'b0, m0_gnt}, 1);
    chk("post_rst_tie_gnt1", {31'b0, m1_gnt}, 0);
    @(posedge clk);
    #1 drive(1, 0, 0, 32'h030, 0, 0, 0, 0, 0, 0);
    #1;
    chk("suppressed_wr_rvalid0", {31'b0, m0_rvalid}, 1);
    chk("suppressed_wr_rdata0", m0_rdata, 0);
    chk("post_rst_rvalid1", {31'b0, m1_rvalid}, 0);
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("burst_first_wr_rdata0", m0_rdata, 32'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
